// File: rtl/ifu_pf_pkg.sv
// Shared types for the instruction prefetch buffer: FIFO entry layout,
// address-phase FSM states and the PC step.
package ifu_pf_pkg;

    localparam logic [31:0] PC_INC = 32'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        err;
    } fetch_entry_t;

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/ifu_pf_fifo.sv
// Synchronous FIFO of fetch entries. Clear beats push/pop; push into a full
// FIFO is honoured only when a pop frees the head in the same cycle.
module ifu_pf_fifo
    import ifu_pf_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         push,
    input  logic                         pop,
    input  fetch_entry_t                 wdata,
    output fetch_entry_t                 rdata,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    // Storage is reset so the head reads as all-zero straight out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/ifu_prefetch_buf.sv
// Instruction fetch unit with prefetch FIFO between an OBI-style bus and decode.
// Define IFU_PREFETCH_PERF_EN to add the fetch/starve performance counters.
module ifu_prefetch_buf
    import ifu_pf_pkg::*;
#(
    parameter logic [31:0] BOOT_ADDR       = 32'h0000_0000,
    parameter int          FIFO_DEPTH      = 4,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush_i,
    input  logic [31:0]  flush_addr_i,
    input  logic         inst_ready_i,
    output logic         inst_valid_o,
    output logic [31:0]  inst_o,
    output logic [31:0]  pc_o,
    output logic         inst_err_o,
    output logic         instr_req_o,
    input  logic         instr_gnt_i,
    input  logic         instr_rvalid_i,
    output logic [31:0]  instr_addr_o,
    input  logic [31:0]  instr_rdata_i,
    input  logic         instr_err_i,
`ifdef IFU_PREFETCH_PERF_EN
    output logic [31:0]  perf_fetch_cnt_o,
    output logic [31:0]  perf_starve_cnt_o,
`endif
    output fetch_state_e fsm_state
);

    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int FW = $clog2(FIFO_DEPTH + 1);

    fetch_state_e  state;
    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [31:0]   hold_addr;
    logic [31:0]   redirect_pc;
    logic [OW-1:0] outstanding;
    logic [OW-1:0] outstanding_nxt;
    logic [OW-1:0] discard_cnt;
    logic          err_lock;
    logic          stale_hold;
    logic [FW-1:0] fifo_count;
    logic          fifo_empty;
    logic          fifo_full;
    fetch_entry_t  fifo_wdata;
    fetch_entry_t  head;
    logic          room;
    logic          grant;
    logic          rsp;
    logic          discard_rsp;
    logic          push;
    logic          pop;

    // Reserving FIFO space for every in-flight request makes overflow impossible.
    assign room = (int'(outstanding) < MAX_OUTSTANDING)
               && (int'(outstanding) + int'(fifo_count) < FIFO_DEPTH)
               && !fifo_full;

    assign instr_req_o  = !rst && ((state == HOLD) || (!err_lock && room && !flush_i));
    assign instr_addr_o = (state == HOLD) ? hold_addr : fetch_pc;
    assign redirect_pc  = flush_addr_i & ~32'd3;

    // Responses with nothing outstanding (e.g. just after reset) are ignored.
    assign grant           = instr_req_o && instr_gnt_i;
    assign rsp             = instr_rvalid_i && (outstanding != '0);
    assign discard_rsp     = rsp && (discard_cnt != '0);
    assign push            = rsp && !discard_rsp && !flush_i;
    assign pop             = inst_valid_o && inst_ready_i;
    assign outstanding_nxt = outstanding + OW'(grant) - OW'(rsp);
    assign fifo_wdata      = '{pc: resp_pc, inst: instr_rdata_i, err: instr_err_i};

    ifu_pf_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (flush_i),
        .push  (push),
        .pop   (pop),
        .wdata (fifo_wdata),
        .rdata (head),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign inst_valid_o = !fifo_empty;
    assign inst_o       = head.inst;
    assign pc_o         = head.pc;
    assign inst_err_o   = head.err;
    assign fsm_state    = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            fetch_pc    <= BOOT_ADDR;
            resp_pc     <= BOOT_ADDR;
            hold_addr   <= BOOT_ADDR;
            outstanding <= '0;
            discard_cnt <= '0;
            err_lock    <= 1'b0;
            stale_hold  <= 1'b0;
        end else begin
            outstanding <= outstanding_nxt;
            case (state)
                RUN: begin
                    if (instr_req_o && !instr_gnt_i) begin
                        state     <= HOLD;
                        hold_addr <= fetch_pc;
                    end
                end
                HOLD: begin
                    if (instr_gnt_i) begin
                        state <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
            // A request still waiting in HOLD across a flush is stale: its
            // grant is added to the discard count and does not advance fetch_pc.
            if (flush_i) begin
                fetch_pc    <= redirect_pc;
                resp_pc     <= redirect_pc;
                err_lock    <= 1'b0;
                discard_cnt <= outstanding_nxt;
                stale_hold  <= (state == HOLD) && !instr_gnt_i;
            end else begin
                if (grant && !stale_hold) begin
                    fetch_pc <= fetch_pc + PC_INC;
                end
                if (grant) begin
                    stale_hold <= 1'b0;
                end
                if (push) begin
                    resp_pc <= resp_pc + PC_INC;
                    if (instr_err_i) begin
                        err_lock <= 1'b1;
                    end
                end
                discard_cnt <= discard_cnt - OW'(discard_rsp) + OW'(grant && stale_hold);
            end
        end
    end

`ifdef IFU_PREFETCH_PERF_EN
    // Pops coinciding with a flush are not delivered, so they are not counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_cnt_o  <= '0;
            perf_starve_cnt_o <= '0;
        end else begin
            if (pop && !flush_i) begin
                perf_fetch_cnt_o <= perf_fetch_cnt_o + 32'd1;
            end
            if (inst_ready_i && !inst_valid_o) begin
                perf_starve_cnt_o <= perf_starve_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ifu_prefetch_buf.sv
// Randomised bench for ifu_prefetch_buf: a bus responder plus a stream-level
// model of the expected instruction sequence, checked by a separate monitor.
module tb_ifu_prefetch_buf;
  import ifu_pf_pkg::*;

  localparam logic [31:0] BOOT  = 32'h0000_0100;
  localparam int          DEPTH = 4;
  localparam int          MAXO  = 2;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         flush_i = 1'b0;
  logic [31:0]  flush_addr_i = '0;
  logic         inst_ready_i = 1'b0;
  logic         instr_gnt_i = 1'b0;
  logic         instr_rvalid_i = 1'b0;
  logic [31:0]  instr_rdata_i = '0;
  logic         instr_err_i = 1'b0;
  logic         inst_valid_o;
  logic [31:0]  inst_o;
  logic [31:0]  pc_o;
  logic         inst_err_o;
  logic         instr_req_o;
  logic [31:0]  instr_addr_o;
  fetch_state_e fsm_state;
`ifdef IFU_PREFETCH_PERF_EN
  logic [31:0]  perf_fetch_cnt_o;
  logic [31:0]  perf_starve_cnt_o;
`endif

  always #5 clk = ~clk;

  ifu_prefetch_buf #(
    .BOOT_ADDR       (BOOT),
    .FIFO_DEPTH      (DEPTH),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .flush_i           (flush_i),
    .flush_addr_i      (flush_addr_i),
    .inst_ready_i      (inst_ready_i),
    .inst_valid_o      (inst_valid_o),
    .inst_o            (inst_o),
    .pc_o              (pc_o),
    .inst_err_o        (inst_err_o),
    .instr_req_o       (instr_req_o),
    .instr_gnt_i       (instr_gnt_i),
    .instr_rvalid_i    (instr_rvalid_i),
    .instr_addr_o      (instr_addr_o),
    .instr_rdata_i     (instr_rdata_i),
    .instr_err_i       (instr_err_i),
`ifdef IFU_PREFETCH_PERF_EN
    .perf_fetch_cnt_o  (perf_fetch_cnt_o),
    .perf_starve_cnt_o (perf_starve_cnt_o),
`endif
    .fsm_state         (fsm_state)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int passed = 0;

  typedef struct {
    logic [31:0] addr;
    int          epoch;
  } pend_t;

  pend_t       pend_q[$];
  logic [64:0] exp_q[$];          // {pc, inst, err}

  int          epoch = 0;
  int          req_epoch = 0;
  logic [31:0] req_addr = '0;
  bit          waiting = 0;
  bit          locked = 0;
  logic [31:0] model_fetch_pc = BOOT;
  logic [31:0] model_resp_pc = BOOT;
  bit          clr_pending = 0;
  bit          push_pending = 0;
  logic [64:0] push_entry = '0;
  bit          rst_applied = 0;
  logic [31:0] m_fetch = '0;
  logic [31:0] m_starve = '0;

  // stimulus knobs (percent)
  int p_gnt = 100, p_rvalid = 100, p_ready = 100, p_flush = 0;
  bit err_en = 0, flush_on_lock = 0, force_flush = 0, ghost = 0;
  int rst_left = 2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic mem_err(input logic [31:0] a);
    return err_en && ((a == 32'h0000_0110) || (a[9:2] == 8'h5D));
  endfunction

  // ---------------- reference model (negedge, sees inputs for next edge) ----------------
  task automatic model_cycle();
    logic  exp_req;
    pend_t p;
    if (rst) begin
      if (rst_applied) begin
        check("reset_req", 32'(instr_req_o), 32'(0));
        check("reset_valid", 32'(inst_valid_o), 32'(0));
        check("reset_inst", inst_o, 32'h0);
        check("reset_pc", pc_o, 32'h0);
        check("reset_err", 32'(inst_err_o), 32'(0));
      end
      pend_q.delete();
      waiting = 0;
      locked = 0;
      epoch++;
      model_fetch_pc = BOOT;
      model_resp_pc = BOOT;
      clr_pending = 1;
      push_pending = 0;
      return;
    end
    exp_req = waiting || (!locked && pend_q.size() < MAXO
              && pend_q.size() + exp_q.size() < DEPTH && !flush_i);
    check("instr_req_o", 32'(instr_req_o), 32'(exp_req));
    if (instr_req_o) begin
      if (waiting) check("hold_addr_stable", instr_addr_o, req_addr);
      else begin
        req_addr = instr_addr_o;
        req_epoch = epoch;
      end
      if (instr_gnt_i) begin
        if (req_epoch == epoch) begin
          check("fetch_addr", req_addr, model_fetch_pc);
          model_fetch_pc += 32'd4;
        end
        pend_q.push_back('{addr: req_addr, epoch: req_epoch});
        waiting = 0;
      end else begin
        waiting = 1;
      end
    end else begin
      waiting = 0;
    end
    push_pending = 0;
    if (instr_rvalid_i && pend_q.size() > 0) begin
      p = pend_q.pop_front();
      if (!flush_i && p.epoch == epoch) begin
        push_entry = {model_resp_pc, instr_rdata_i, instr_err_i};
        push_pending = 1;
        if (instr_err_i) locked = 1;
        model_resp_pc += 32'd4;
      end
    end
    if (flush_i) begin
      epoch++;
      locked = 0;
      model_fetch_pc = flush_addr_i & ~32'd3;
      model_resp_pc = flush_addr_i & ~32'd3;
      clr_pending = 1;
    end
  endtask

  task automatic apply();
    rst_applied = rst;
    if (clr_pending) exp_q.delete();
    if (push_pending) exp_q.push_back(push_entry);
    clr_pending = 0;
    push_pending = 0;
  endtask

  // ---------------- driver ----------------
  task automatic drive();
    rst = (rst_left > 0);
    if (rst_left > 0) rst_left--;
    instr_gnt_i = ($urandom_range(99) < p_gnt);
    if (!rst && pend_q.size() > 0 && $urandom_range(99) < p_rvalid) begin
      instr_rvalid_i = 1'b1;
      instr_rdata_i = mem_data(pend_q[0].addr);
      instr_err_i = mem_err(pend_q[0].addr);
    end else begin
      instr_rvalid_i = 1'b0;
      instr_rdata_i = $urandom;
      instr_err_i = 1'($urandom_range(1));
    end
    if (ghost && !rst && rst_applied) begin
      instr_rvalid_i = 1'b1;
      instr_err_i = 1'b0;
      ghost = 0;
    end
    inst_ready_i = ($urandom_range(99) < p_ready);
    flush_i = !rst && (($urandom_range(99) < p_flush) || force_flush
              || (flush_on_lock && locked && $urandom_range(99) < 20));
    force_flush = 0;
    if ($urandom_range(9) == 0) flush_addr_i = 32'hFFFF_FFF0 | 32'($urandom_range(15));
    else flush_addr_i = $urandom & 32'h0000_0FFF;
  endtask

  task automatic step();
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    apply();
    #1;
    drive();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [64:0] e;
    #1;
    if (rst) begin
      m_fetch = '0;
      m_starve = '0;
    end else begin
`ifdef IFU_PREFETCH_PERF_EN
      check("perf_fetch_cnt_o", perf_fetch_cnt_o, m_fetch);
      check("perf_starve_cnt_o", perf_starve_cnt_o, m_starve);
`endif
      check("inst_valid_o", 32'(inst_valid_o), 32'(exp_q.size() != 0));
      if (inst_valid_o && inst_ready_i && !flush_i && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("pc_o", pc_o, e[64:33]);
        check("inst_o", inst_o, e[32:1]);
        check("inst_err_o", 32'(inst_err_o), 32'(e[0]));
        m_fetch = m_fetch + 32'd1;
      end
      if (inst_ready_i && !inst_valid_o) m_starve = m_starve + 32'd1;
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    // streaming: full grant, immediate responses, consumer always ready
    run(40);
    // back-pressure: buffer must stop at DEPTH entries, then drain in order
    p_ready = 0;
    run(20);
    p_ready = 100;
    run(10);
    // random traffic with flushes, HOLD phases and bus errors
    p_gnt = 60; p_rvalid = 50; p_ready = 70; p_flush = 4;
    err_en = 1; flush_on_lock = 1;
    run(3000);
    // heavy flushing with bursty grants
    p_gnt = 40; p_rvalid = 70; p_flush = 20;
    run(500);
    // mid-transaction reset followed by a stray response
    rst_left = 1; ghost = 1;
    p_flush = 4;
    run(300);
    // wind down: clear any lock and drain
    p_gnt = 100; p_rvalid = 100; p_ready = 100; p_flush = 0;
    err_en = 0; force_flush = 1;
    run(50);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
